prog_ram: RTL



---
 rtl/prog_ram_pkg.sv | 20 ++
 rtl/prog_ram_button_debounce.sv | 118 +++++++++++
 rtl/prog_ram.sv | 139 +++++++++++++
 3 files changed

// File: rtl/prog_ram_pkg.sv
// prog_ram_pkg
//   Shared definitions for the program/data RAM block: the encoding of the
//   write-button state machine and its width.
package prog_ram_pkg;

    localparam int BTN_STATE_W = 2;

    // state    | meaning
    // IDLE     | waiting for a synchronised press
    // DEBOUNCE | press seen, counting consecutive high samples
    // WRITE    | single cycle: commit dip_data to mem[mar]
    // RELEASE  | waiting for a debounced release before re-arming
    typedef enum logic [BTN_STATE_W-1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_WRITE    = 2'd2,
        ST_RELEASE  = 2'd3
    } btn_state_t;

endpackage

// File: rtl/prog_ram_button_debounce.sv
// prog_ram_button_debounce
//   Synchronises the raw write push-button, debounces press and release and
//   emits exactly one write pulse per debounced press.
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_btn_raw        raw, asynchronous, bouncy button
//   i_enable         program mode; low forces the FSM back to IDLE
//   o_write_pulse    high for the one cycle the FSM sits in WRITE
//   o_busy           FSM not in IDLE
module prog_ram_button_debounce
    import prog_ram_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn_raw,
    input  logic i_enable,
    output logic o_write_pulse,
    output logic o_busy
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    // The counter holds the number of samples already accepted; the sample
    // that makes it reach DEBOUNCE_CYCLES causes the transition directly,
    // so the count never exceeds DEBOUNCE_CYCLES-1 and cannot wrap.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             w_btn_s;
    btn_state_t       r_state;
    btn_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    assign w_btn_s = r_sync2;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (!i_enable) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_btn_s) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            w_state_nxt = ST_WRITE;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_state_nxt = ST_DEBOUNCE;
                            w_cnt_nxt   = CNT_W'(1);
                        end
                    end
                end
                ST_DEBOUNCE: begin
                    if (!w_btn_s) begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == CNT_LAST) begin
                        w_state_nxt = ST_WRITE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt   = r_cnt + CNT_W'(1);
                    end
                end
                ST_WRITE: begin
                    w_state_nxt = ST_RELEASE;
                    w_cnt_nxt   = '0;
                end
                ST_RELEASE: begin
                    if (w_btn_s) begin
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == CNT_LAST) begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt   = r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Once WRITE is reached the write is committed even if program mode
    // drops on that same cycle.
    always_comb begin
        o_write_pulse = (r_state == ST_WRITE);
        o_busy        = (r_state != ST_IDLE);
    end

endmodule

// File: rtl/prog_ram.sv
// prog_ram
//   Program/data RAM with its memory address register for the SAP-style CPU.
//   Run mode: MAR and memory are loaded from the shared bus under control
//   strobes. Program mode: hand-loaded from DIP switches through a debounced
//   write button, with optional MAR auto-increment.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   prog_mode         1 = DIP programming, 0 = run mode
//   dip_addr/data     programming switches
//   write_button      raw push-button
//   auto_inc          program mode MAR post-increment after each write
//   bus_in            shared bus value
//   load_addr         run mode MAR load from bus
//   write_enable      run mode memory write from bus
//   output_enable     request a read onto the bus
//   bus_out/bus_drive registered read data and its valid flag
//   mar               current MAR
//   prog_busy         button FSM active
module prog_ram
    import prog_ram_pkg::*;
#(
    parameter int DATA_W          = 8,
    parameter int ADDR_W          = 4,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              prog_mode,
    input  logic [ADDR_W-1:0] dip_addr,
    input  logic [DATA_W-1:0] dip_data,
    input  logic              write_button,
    input  logic              auto_inc,
    input  logic [DATA_W-1:0] bus_in,
    input  logic              load_addr,
    input  logic              write_enable,
    input  logic              output_enable,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_drive,
    output logic [ADDR_W-1:0] mar,
    output logic              prog_busy
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0] r_mar;
    logic [ADDR_W-1:0] w_mar_nxt;
    logic              r_prog_mode_d;
    logic              r_auto_inc_d;
    logic [DATA_W-1:0] r_bus_out;
    logic              r_bus_drive;
    logic              w_write_pulse;
    logic              w_prog_busy;
    logic              w_run_write;
    logic              w_mem_we;
    logic [DATA_W-1:0] w_mem_wdata;
    logic              w_dip_load;

    prog_ram_button_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_btn_raw     (write_button),
        .i_enable      (prog_mode),
        .o_write_pulse (w_write_pulse),
        .o_busy        (w_prog_busy)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prog_mode_d <= 1'b0;
            r_auto_inc_d  <= 1'b0;
        end else begin
            r_prog_mode_d <= prog_mode;
            r_auto_inc_d  <= auto_inc;
        end
    end

    // In program mode the switches own the MAR unless auto-increment is
    // running; auto-increment re-seeds from the switches only when program
    // mode is entered or auto_inc is switched on.
    assign w_dip_load = !auto_inc || !r_prog_mode_d || !r_auto_inc_d;

    always_comb begin
        w_mar_nxt = r_mar;
        if (prog_mode) begin
            if (w_dip_load) begin
                w_mar_nxt = dip_addr;
            end else if (w_write_pulse) begin
                w_mar_nxt = r_mar + ADDR_W'(1);
            end
        end else begin
            if (load_addr) begin
                w_mar_nxt = bus_in[ADDR_W-1:0];
            end else if (w_write_pulse && auto_inc) begin
                w_mar_nxt = r_mar + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mar <= '0;
        end else begin
            r_mar <= w_mar_nxt;
        end
    end

    // A bus write takes priority; a button write can only coincide with run
    // mode on the cycle program mode drops while the FSM is in WRITE.
    assign w_run_write = !prog_mode && write_enable;
    assign w_mem_we    = w_run_write || w_write_pulse;
    assign w_mem_wdata = w_run_write ? bus_in : dip_data;

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[r_mar] <= w_mem_wdata;
        end
    end

    // Read register samples the array before this edge's write lands,
    // giving read-first behaviour on address collisions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bus_out   <= '0;
            r_bus_drive <= 1'b0;
        end else begin
            r_bus_drive <= output_enable;
            r_bus_out   <= output_enable ? r_mem[r_mar] : '0;
        end
    end

    assign bus_out   = r_bus_out;
    assign bus_drive = r_bus_drive;
    assign mar       = r_mar;
    assign prog_busy = w_prog_busy;

endmodule
